c17_bist_ctrl: RTL and testbench
================================

Name: c17_bist_ctrl

Overview:
Built-in self-test sequencer for the c17 NAND2 netlist.
- Generates pseudo-random 5-bit stimulus with an LFSR.
- Holds each pattern for a fixed settle window, then compresses the two c17 outputs into a MISR signature.
- Compares the signature against a golden value.
- Sits beside the c17 instance; a test/host controller starts runs and reads the result.

Parameters:
SETTLE, 2, APPLY cycles per pattern before capture (>=1)
MISR_W, 8, signature width (>=2)
MISR_POLY, 8'h71, Galois feedback mask (x^8+x^6+x^5+x^4+1)
LFSR_SEED, 5'h01, first pattern; must be nonzero

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  begin run; sampled in IDLE or DONE only
num_patterns  in  8  patterns per run; latched on accepted start
golden  in  MISR_W  expected signature; sampled continuously
dut_in  out  5  to c17: [4:2]=test[2:0], [1]=nx2, [0]=nx6
dut_out  in  2  from c17: [1]=nx23, [0]=nx22
busy  out  1  high in APPLY/CAPTURE
done  out  1  high in DONE
signature  out  MISR_W  current MISR value
pass  out  1  done && (signature==golden)

Behaviour:
Reset:
- state=IDLE; dut_in=0; lfsr=LFSR_SEED; misr=0; count=0.
- busy, done and pass =0.
- Reset mid-run aborts immediately to this state; no partial result is kept.

States and transitions:
- IDLE: dut_in=0.
  - start=1 with num_patterns=0: go to DONE with misr=0.
  - start=1 otherwise: latch N=num_patterns, set lfsr=LFSR_SEED, misr=0, count=0, settle counter=0; go to APPLY.
- APPLY: dut_in=lfsr. Count SETTLE cycles, then go to CAPTURE.
- CAPTURE: dut_in=lfsr, still held. On the exiting edge:
  - MISR update: misr <= ((misr<<1) ^ (misr[MISR_W-1] ? MISR_POLY : 0)) ^ {0..,dut_out}. Shift is truncated to MISR_W bits.
  - LFSR update: lfsr <= {lfsr[3:0], lfsr[4]^lfsr[2]} (x^5+x^3+1, period 31).
  - count++.
  - Next state: DONE if count+1==N, else APPLY with settle counter cleared.
- DONE: dut_in=0. signature is frozen; done=1 and pass is valid.
  - start=1 restarts exactly as from IDLE.
  - Otherwise stay in DONE.

Timing and sequencing:
- start asserted while busy is ignored.
- Latency: done rises N*(SETTLE+1) cycles after the edge that accepted start.
- The pattern sequence restarts from LFSR_SEED every run.
- N>31 repeats patterns; this is legal.
- dut_out is sampled only in CAPTURE. It is ignored in all other states.
- signature tracks misr at all times. pass is 0 outside DONE.

Decomposition:
- Package c17_bist_pkg holds:
  - state enum {IDLE, APPLY, CAPTURE, DONE};
  - LFSR tap positions and default seed;
  - default MISR_POLY;
  - dut_in bit-index constants (TEST2..TEST0, NX2, NX6) and dut_out indices (NX23, NX22).
- One sub-module, bist_misr: parameterised MISR_W/MISR_POLY, with clear/enable/data inputs and value output.
- The FSM, LFSR and counters stay in c17_bist_ctrl.

Test Plan:
- Reset, then start with N=5 and dut_out tied 00: dut_in sequence is 01,02,04,09,12. Each pattern is held 3 cycles. done rises 15 cycles after start; signature=0x00.
- dut_out tied 11, N=2, golden=0x05: signature goes 0x03 after pattern 0, then 0x05. pass=1. Repeat with golden=0x04: pass=0.
- Real c17 attached, N=1: dut_in=01 (test=000, nx2=0, nx6=1). Captured outputs 00; signature=0x00.
- N=0: done one cycle after start, busy never high, signature=0x00. start pulses while busy are ignored; the run still ends at the original time.
- rst asserted in APPLY of pattern 3: the next cycle shows IDLE, dut_in=0, signature=0, done=0. A fresh start reproduces the full-run signature.
- Back-to-back: start in DONE with N=3 clears the signature and restarts from pattern 01. The result equals a run started from IDLE.

Source files
------------

// File: rtl/c17_bist_pkg.sv
// Shared types and constants for the c17 BIST sequencer: FSM state
// encoding, LFSR taps and seed, MISR polynomial and the bit positions
// of the signals exchanged with the c17 netlist.
package c17_bist_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        APPLY   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Stimulus LFSR: x^5 + x^3 + 1, maximal length (period 31)
    localparam int          LFSR_W            = 5;
    localparam int          LFSR_TAP_HI       = 4;
    localparam int          LFSR_TAP_LO       = 2;
    localparam logic [4:0]  DEFAULT_LFSR_SEED = 5'h01;

    // Signature compressor: x^8 + x^6 + x^5 + x^4 + 1 (Galois form)
    localparam logic [7:0]  DEFAULT_MISR_POLY = 8'h71;

    // dut_in bit positions towards the c17 inputs
    localparam int TEST2 = 4;
    localparam int TEST1 = 3;
    localparam int TEST0 = 2;
    localparam int NX2   = 1;
    localparam int NX6   = 0;

    // dut_out bit positions from the c17 outputs
    localparam int NX23  = 1;
    localparam int NX22  = 0;

    // Advance the stimulus LFSR by one step
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0], cur[LFSR_TAP_HI] ^ cur[LFSR_TAP_LO]};
    endfunction

    // Route an LFSR pattern onto the named c17 input pins
    function automatic logic [4:0] pattern_to_dut_in(input logic [LFSR_W-1:0] pat);
        logic [4:0] v;
        v        = '0;
        v[TEST2] = pat[4];
        v[TEST1] = pat[3];
        v[TEST0] = pat[2];
        v[NX2]   = pat[1];
        v[NX6]   = pat[0];
        return v;
    endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register folding the two c17 outputs into a
// Galois-style signature. clear wins over enable.
module bist_misr
    import c17_bist_pkg::*;
#(
    parameter int                MISR_W    = 8,
    parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(DEFAULT_MISR_POLY)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic [1:0]        data,
    output logic [MISR_W-1:0] value
);

    // Shift with polynomial feedback and XOR in the captured response
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            value <= '0;
        end else if (enable) begin
            value <= ({value[MISR_W-2:0], 1'b0} ^ (value[MISR_W-1] ? MISR_POLY : '0))
                     ^ MISR_W'(data);
        end
    end

endmodule

// File: rtl/c17_bist_ctrl.sv
// BIST sequencer for the c17 netlist: drives LFSR patterns, holds each
// for a settle window, captures the response into a MISR and reports
// whether the final signature matches the golden value.
module c17_bist_ctrl
    import c17_bist_pkg::*;
#(
    parameter int                SETTLE    = 2,
    parameter int                MISR_W    = 8,
    parameter logic [MISR_W-1:0] MISR_POLY = MISR_W'(DEFAULT_MISR_POLY),
    parameter logic [4:0]        LFSR_SEED = DEFAULT_LFSR_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        num_patterns,
    input  logic [MISR_W-1:0] golden,
    output logic [4:0]        dut_in,
    input  logic [1:0]        dut_out,
    output logic              busy,
    output logic              done,
    output logic [MISR_W-1:0] signature,
    output logic              pass
);

    localparam int                SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE - 1);

    state_t        state;
    logic [4:0]    lfsr;
    logic [7:0]    count;
    logic [7:0]    n_latched;
    logic [SW-1:0] settle_cnt;
    logic          start_ok;
    logic          last_pattern;
    logic          misr_clear;
    logic          misr_enable;
    logic [1:0]    capture_data;
    logic [4:0]    lfsr_adv;

    assign start_ok     = start && ((state == IDLE) || (state == DONE));
    assign last_pattern = ({1'b0, count} + 9'd1) == {1'b0, n_latched};
    assign lfsr_adv     = lfsr_next(lfsr);
    assign misr_clear   = start_ok;
    assign misr_enable  = (state == CAPTURE);
    assign capture_data = {dut_out[NX23], dut_out[NX22]};

    // Sequencer: accepts runs, steps patterns through settle and capture,
    // and owns the registered pin/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lfsr       <= LFSR_SEED;
            count      <= '0;
            n_latched  <= '0;
            settle_cnt <= '0;
            dut_in     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        lfsr       <= LFSR_SEED;
                        count      <= '0;
                        settle_cnt <= '0;
                        n_latched  <= num_patterns;
                        if (num_patterns == 8'd0) begin
                            state  <= DONE;
                            dut_in <= '0;
                            busy   <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            state  <= APPLY;
                            dut_in <= pattern_to_dut_in(LFSR_SEED);
                            busy   <= 1'b1;
                            done   <= 1'b0;
                        end
                    end
                end
                APPLY: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state      <= CAPTURE;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    lfsr  <= lfsr_adv;
                    count <= count + 8'd1;
                    if (last_pattern) begin
                        state  <= DONE;
                        dut_in <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        state      <= APPLY;
                        settle_cnt <= '0;
                        dut_in     <= pattern_to_dut_in(lfsr_adv);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    bist_misr #(
        .MISR_W    (MISR_W),
        .MISR_POLY (MISR_POLY)
    ) u_misr (
        .clk    (clk),
        .rst    (rst),
        .clear  (misr_clear),
        .enable (misr_enable),
        .data   (capture_data),
        .value  (signature)
    );

    assign pass = done && (signature == golden);

endmodule

// File: tb/tb_c17_bist_ctrl.sv
// Self-checking bench for c17_bist_ctrl. A response table stands in for
// the c17 netlist (constant, true c17 logic, or random) and a small
// arithmetic model predicts patterns, signatures and latency.
module tb_c17_bist_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] num_patterns;
    logic [7:0] golden;
    logic [4:0] dut_in;
    logic [1:0] dut_out;
    logic       busy;
    logic       done;
    logic [7:0] signature;
    logic       pass;

    logic [1:0] resp [32];
    int         checks = 0;
    int         errors = 0;

    c17_bist_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_patterns (num_patterns),
        .golden       (golden),
        .dut_in       (dut_in),
        .dut_out      (dut_out),
        .busy         (busy),
        .done         (done),
        .signature    (signature),
        .pass         (pass)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Device-under-test stand-in: response looked up from the current pins
    always_comb dut_out = resp[dut_in];

    // Gate-level c17: test[2:0] -> N1,N3,N7, nx2 -> N2, nx6 -> N6
    function automatic logic [1:0] c17(input logic [4:0] v);
        logic n1, n2, n3, n6, n7, g10, g11, g16, g19;
        n1 = v[4]; n3 = v[3]; n7 = v[2]; n2 = v[1]; n6 = v[0];
        g10 = ~(n1 & n3);
        g11 = ~(n3 & n6);
        g16 = ~(n2 & g11);
        g19 = ~(g11 & n7);
        return {~(g16 & g19), ~(g10 & g16)};
    endfunction

    // k-th stimulus pattern of a run, from the x^5+x^3+1 recurrence
    function automatic int model_pat(input int k);
        int p = 1;
        for (int i = 0; i < k; i++)
            p = ((p * 2) % 32) + (((p / 16) % 2) ^ ((p / 4) % 2));
        return p;
    endfunction

    // Signature after k captured patterns of a run
    function automatic int model_sig(input int k);
        int m = 0;
        int s;
        for (int i = 0; i < k; i++) begin
            s = (m * 2) % 256;
            if (m >= 128) s = s ^ 'h71;
            m = s ^ int'(resp[model_pat(i)]);
        end
        return m;
    endfunction

    task automatic fillTable(input int mode, input int value);
        for (int i = 0; i < 32; i++) begin
            if (mode == 0)      resp[i] = 2'(value);
            else if (mode == 1) resp[i] = c17(5'(i));
            else                resp[i] = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One full run: start pulse, per-cycle checks while busy, end checks
    task automatic applyStimulus(input string tag, input int n, input int glitch_cycle);
        int c;
        int k;
        int final_sig;
        final_sig = model_sig(n);
        @(negedge clk);
        start        = 1'b1;
        num_patterns = 8'(n);
        @(negedge clk);
        start = 1'b0;
        c = 1;
        checkOutput({tag, ".sig_clear"}, 32'(signature), 32'(model_sig(0)));
        while (!done && c <= n * 3 + 8) begin
            k = (c - 1) / 3;
            checkOutput({tag, ".busy"}, 32'(busy), 32'd1);
            if (k < n) begin
                checkOutput({tag, ".dut_in"}, 32'(dut_in), 32'(model_pat(k)));
                checkOutput({tag, ".sig_run"}, 32'(signature), 32'(model_sig(k)));
            end
            if (c == glitch_cycle) begin
                start        = 1'b1;
                num_patterns = 8'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        checkOutput({tag, ".latency"}, 32'(c - 1), 32'(n * 3));
        checkOutput({tag, ".done"}, 32'(done), 32'd1);
        checkOutput({tag, ".busy_end"}, 32'(busy), 32'd0);
        checkOutput({tag, ".dut_in_end"}, 32'(dut_in), 32'd0);
        checkOutput({tag, ".sig"}, 32'(signature), 32'(final_sig));
        checkOutput({tag, ".pass"}, 32'(pass), 32'(final_sig == int'(golden)));
        @(negedge clk);
        checkOutput({tag, ".done_hold"}, 32'(done), 32'd1);
        checkOutput({tag, ".sig_hold"}, 32'(signature), 32'(final_sig));
    endtask

    // Directed scenarios followed by randomized runs
    initial begin
        int n;
        int gl;
        rst          = 1'b1;
        start        = 1'b0;
        num_patterns = 8'd0;
        golden       = 8'h00;
        fillTable(0, 0);
        repeat (3) @(negedge clk);
        checkOutput("reset.dut_in", 32'(dut_in), 32'd0);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.done", 32'(done), 32'd0);
        checkOutput("reset.pass", 32'(pass), 32'd0);
        checkOutput("reset.sig", 32'(signature), 32'd0);
        rst = 1'b0;

        $display("[TB] constant-00 response, N=5");
        applyStimulus("n5_zero", 5, 0);

        $display("[TB] constant-11 response, N=2, golden match then mismatch");
        fillTable(0, 3);
        golden = 8'h05;
        applyStimulus("n2_ones_pass", 2, 0);
        golden = 8'h04;
        applyStimulus("n2_ones_fail", 2, 0);

        $display("[TB] real c17 attached, N=1");
        fillTable(1, 0);
        golden = 8'h00;
        applyStimulus("c17_n1", 1, 0);

        $display("[TB] N=0 and start ignored while busy");
        fillTable(0, 3);
        golden = 8'h00;
        applyStimulus("n0", 0, 0);
        applyStimulus("glitch_n4", 4, 5);

        $display("[TB] reset during APPLY of pattern 3");
        fillTable(2, 0);
        @(negedge clk);
        start        = 1'b1;
        num_patterns = 8'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("abort.pattern3", 32'(dut_in), 32'(model_pat(3)));
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort.dut_in", 32'(dut_in), 32'd0);
        checkOutput("abort.sig", 32'(signature), 32'd0);
        checkOutput("abort.done", 32'(done), 32'd0);
        checkOutput("abort.busy", 32'(busy), 32'd0);
        rst = 1'b0;
        golden = 8'(model_sig(5));
        applyStimulus("abort_rerun", 5, 0);

        $display("[TB] back-to-back restart from DONE");
        applyStimulus("b2b_n3", 3, 0);

        $display("[TB] randomized runs");
        for (int r = 0; r < 8; r++) begin
            fillTable(2, 0);
            n  = $urandom_range(1, 40);
            gl = ($urandom_range(0, 1) == 1) ? model_sig(n) : int'($urandom_range(0, 255));
            golden = 8'(gl);
            applyStimulus($sformatf("rand%0d", r), n, $urandom_range(1, n * 3 - 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
